// File: rtl/dmem_line_bridge_pkg.sv
// Shared constants for the data-cache line bridge: line/beat geometry and FSM state codes.
package dmem_line_bridge_pkg;

    localparam int LINE_W     = 1024;
    localparam int BEAT_W     = 64;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int OFFS_W     = 7;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    // Byte offset of a beat within the line: one beat is 8 bytes.
    localparam int BEAT_SHIFT = OFFS_W - BEAT_CNT_W;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_BURST = 3'd1;
    localparam logic [2:0] ST_RD_DONE  = 3'd2;
    localparam logic [2:0] ST_WR_CAPT  = 3'd3;
    localparam logic [2:0] ST_WR_BURST = 3'd4;

endpackage

// File: rtl/dmem_line_bridge.sv
// Splits 1024-bit cache line fills and write-throughs into 16 sequential 64-bit memory beats,
// with a single-entry write-pending latch so a write-through arriving mid-transfer is served later.
module dmem_line_bridge
    import dmem_line_bridge_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic              c_rd,
    input  logic              c_wr,
    input  logic [LINE_W-1:0] c_wdata,
    output logic [LINE_W-1:0] c_rdata,
    output logic              c_dv,
    output logic              busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_req,
    output logic              m_we,
    output logic [BEAT_W-1:0] m_wdata,
    input  logic [BEAT_W-1:0] m_rdata,
    input  logic              m_ack
);

    logic [2:0]               state;
    logic [BEAT_CNT_W-1:0]    beat;
    logic                     pending;
    logic [ADDR_W-OFFS_W-1:0] line_tag;
    logic [LINE_W-1:0]        rd_buf;
    logic [LINE_W-1:0]        wr_buf;
    logic                     in_burst;
    logic                     last_beat;
    logic                     unused_addr_bits;

    // The offset bits inside a line are don't-care; the line base always has them at zero.
    assign unused_addr_bits = ^c_addr[OFFS_W-1:0];

    assign in_burst  = (state == ST_RD_BURST) || (state == ST_WR_BURST);
    assign last_beat = (beat == BEAT_CNT_W'(BEATS - 1));

    // NOTE: every register here, including the two line buffers, is reset so that
    // c_rdata, m_wdata and m_addr read as zero after clr; the buffers are flops, not a RAM.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every branch sees the pre-edge state.
        if (clr) begin
            state    <= ST_IDLE;
            beat     <= '0;
            pending  <= 1'b0;
            line_tag <= '0;
            rd_buf   <= '0;
            wr_buf   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A write (new or pending) wins over a read request.
                    if (pending || c_wr) begin
                        line_tag <= c_addr[ADDR_W-1:OFFS_W];
                        state    <= ST_WR_CAPT;
                    end else if (c_rd) begin
                        line_tag <= c_addr[ADDR_W-1:OFFS_W];
                        state    <= ST_RD_BURST;
                    end
                end

                ST_WR_CAPT: begin
                    // A c_wr landing here merges into this capture rather than queueing another write.
                    wr_buf  <= c_wdata;
                    pending <= 1'b0;
                    state   <= ST_WR_BURST;
                end

                ST_RD_BURST, ST_WR_BURST: begin
                    if (c_wr) begin
                        pending <= 1'b1;
                    end
                    if (m_ack) begin
                        if (state == ST_RD_BURST) begin
                            rd_buf[beat*BEAT_W +: BEAT_W] <= m_rdata;
                        end
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            state <= (state == ST_RD_BURST) ? ST_RD_DONE : ST_IDLE;
                        end
                    end
                end

                ST_RD_DONE: begin
                    if (c_wr) begin
                        pending <= 1'b1;
                    end
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The beat counter only advances on an ack, so a wait state holds address and data stable.
    assign m_req   = in_burst;
    assign m_we    = (state == ST_WR_BURST);
    assign m_addr  = {line_tag, beat, {BEAT_SHIFT{1'b0}}};
    assign m_wdata = wr_buf[beat*BEAT_W +: BEAT_W];
    assign c_rdata = rd_buf;
    assign c_dv    = (state == ST_RD_DONE);
    assign busy    = (state != ST_IDLE) || pending;

endmodule

// File: tb/tb_dmem_line_bridge.sv
// Directed bench for dmem_line_bridge: a transaction-level model checked every cycle,
// plus hand-computed literal expectations along each scenario.
module tb_dmem_line_bridge;
    import dmem_line_bridge_pkg::*;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              clr;
    logic [ADDR_W-1:0] c_addr;
    logic              c_rd;
    logic              c_wr;
    logic [LINE_W-1:0] c_wdata;
    logic [LINE_W-1:0] c_rdata;
    logic              c_dv;
    logic              busy;
    logic [ADDR_W-1:0] m_addr;
    logic              m_req;
    logic              m_we;
    logic [BEAT_W-1:0] m_wdata;
    logic [BEAT_W-1:0] m_rdata;
    logic              m_ack;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit ack_slow = 1'b0;

    dmem_line_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .clr     (clr),
        .c_addr  (c_addr),
        .c_rd    (c_rd),
        .c_wr    (c_wr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_dv    (c_dv),
        .busy    (busy),
        .m_addr  (m_addr),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory content is a fixed function of the beat address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0], ~a[31:0]};
    endfunction

    assign m_ack   = ack_slow ? (cyc % 3 == 0) : 1'b1;
    assign m_rdata = mem_word(m_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: job 0 = none, 1 = line read, 2 = line write.
    // step 0 = write data capture, 1..16 = beat number + 1, 17 = read delivery.
    int                job = 0;
    int                step = 0;
    bit                pend_m = 1'b0;
    bit                rst_seen = 1'b0;
    bit                started = 1'b0;
    logic [ADDR_W-1:0] base_m = '0;
    logic [LINE_W-1:0] wline_m = '0;

    always @(posedge clk) begin
        if (clr) begin
            job      <= 0;
            step     <= 0;
            pend_m   <= 1'b0;
            base_m   <= '0;
            wline_m  <= '0;
            rst_seen <= 1'b1;
            started  <= 1'b1;
        end else begin
            rst_seen <= 1'b0;
            if (job == 0) begin
                if (pend_m || c_wr) begin
                    job    <= 2;
                    step   <= 0;
                    base_m <= c_addr & ~64'h7F;
                end else if (c_rd) begin
                    job    <= 1;
                    step   <= 1;
                    base_m <= c_addr & ~64'h7F;
                end
            end else if (job == 2 && step == 0) begin
                wline_m <= c_wdata;
                pend_m  <= 1'b0;
                step    <= 1;
            end else begin
                if (c_wr) pend_m <= 1'b1;
                if (job == 1 && step == 17) job <= 0;
                else if (m_ack) begin
                    if (job == 2 && step == 16) job <= 0;
                    else step <= step + 1;
                end
            end
        end
    end

    function automatic bit exp_req();
        return (job != 0) && (step >= 1) && (step <= 16);
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("m_req", m_req, exp_req());
            check("m_we", m_we, exp_req() && job == 2);
            check("c_dv", c_dv, job == 1 && step == 17);
            check("busy", busy, job != 0 || pend_m);
            if (exp_req()) begin
                check("m_addr", m_addr, base_m + 64'(8 * (step - 1)));
                if (job == 2) check("m_wdata", m_wdata, wline_m[64*(step-1) +: 64]);
            end
            if (job == 1 && step == 17) begin
                for (int i = 0; i < BEATS; i++)
                    check("c_rdata_beat", c_rdata[64*i +: 64], mem_word(base_m + 64'(8 * i)));
            end
            if (rst_seen) begin
                check("rst_m_addr", m_addr, 64'h0);
                check("rst_m_wdata", m_wdata, 64'h0);
                check("rst_c_rdata_or", |c_rdata, 64'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        int dvs;
        int wb;
        int dv_cyc;
        bit got;

        clr = 1'b1; c_rd = 1'b0; c_wr = 1'b0; c_addr = '0; c_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_m_req_lit", m_req, 0);
        check("rst_busy_lit", busy, 0);
        check("rst_c_dv_lit", c_dv, 0);
        check("rst_m_addr_lit", m_addr, 0);
        clr = 1'b0;

        // Read fill, zero-wait memory.
        c_addr = 64'h1234_5678_9ABC_DEF5;
        c_rd   = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("rd1_first_req", m_req, 1);
                check("rd1_first_addr", m_addr, 64'h1234_5678_9ABC_DE80);
            end
            if (n == 16) begin
                check("rd1_last_addr", m_addr, 64'h1234_5678_9ABC_DEF8);
                check("rd1_no_early_dv", c_dv, 0);
            end
            if (n == 17) begin
                check("rd1_dv_cycle17", c_dv, 1);
                check("rd1_req_low", m_req, 0);
                check("rd1_beat0_lit", c_rdata[63:0], 64'h9ABC_DE80_6543_217F);
                check("rd1_beat15_lit", c_rdata[1023:960], 64'h9ABC_DEF8_6543_2107);
            end
        end
        c_rd = 1'b0;
        @(negedge clk);
        check("rd1_idle_busy", busy, 0);
        check("rd1_dv_single", c_dv, 0);

        // Read fill with an ack every third cycle.
        ack_slow = 1'b1;
        c_addr   = 64'h0000_0000_0000_1040;
        c_rd     = 1'b1;
        acks = 0; dvs = 0; got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (m_req && m_ack) acks++;
            if (c_dv) begin got = 1'b1; dvs++; end
        end
        c_rd = 1'b0;
        check("rd2_dv_seen", got, 1);
        check("rd2_ack_count", acks, 16);
        repeat (3) begin
            @(negedge clk);
            if (c_dv) dvs++;
        end
        check("rd2_dv_count", dvs, 1);
        ack_slow = 1'b0;

        // Single write-through pulse.
        c_addr = 64'h0000_0000_0000_2033;
        for (int i = 0; i < BEATS; i++) c_wdata[64*i +: 64] = 64'hA5A5_0000_0000_0000 + 64'(i);
        c_wr = 1'b1;
        dvs = 0;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (c_dv) dvs++;
            if (n == 1) begin
                c_wr = 1'b0;
                check("wr_capt_busy", busy, 1);
                check("wr_capt_no_req", m_req, 0);
            end
            if (n == 2) begin
                check("wr_first_we", m_we, 1);
                check("wr_first_data", m_wdata, 64'hA5A5_0000_0000_0000);
                check("wr_first_addr", m_addr, 64'h2000);
            end
            if (n == 17) begin
                check("wr_last_data", m_wdata, 64'hA5A5_0000_0000_000F);
                check("wr_last_addr", m_addr, 64'h2078);
            end
            if (n == 18) begin
                check("wr_done_busy", busy, 0);
                check("wr_done_req", m_req, 0);
            end
        end
        check("wr_no_dv", dvs, 0);

        // Write-through arriving in the read-delivery cycle.
        c_addr = 64'h0000_0000_0000_3000;
        c_rd   = 1'b1;
        got    = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (c_dv) got = 1'b1;
        end
        check("rdwr_dv_seen", got, 1);
        c_rd = 1'b0;
        c_wr = 1'b1;
        for (int i = 0; i < BEATS; i++) c_wdata[64*i +: 64] = 64'h5A5A_0000_0000_0000 + 64'(i);
        @(negedge clk);
        c_wr = 1'b0;
        check("rdwr_pending_busy", busy, 1);
        check("rdwr_pending_no_req", m_req, 0);
        @(negedge clk);
        check("rdwr_capt_no_req", m_req, 0);
        @(negedge clk);
        check("rdwr_first_we", m_we, 1);
        check("rdwr_first_addr", m_addr, 64'h3000);
        check("rdwr_first_data", m_wdata, 64'h5A5A_0000_0000_0000);
        wb = 0; got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (m_req && m_we) wb++;
            if (!busy) got = 1'b1;
            else @(negedge clk);
        end
        check("rdwr_idle_reached", got, 1);
        check("rdwr_write_beats", wb, 16);

        // Read and write requested together: write first, then the read.
        c_addr = 64'h0000_0000_0000_4010;
        for (int i = 0; i < BEATS; i++) c_wdata[64*i +: 64] = 64'hC3C3_0000_0000_0000 + 64'(i);
        c_rd = 1'b1;
        c_wr = 1'b1;
        @(negedge clk);
        c_wr = 1'b0;
        check("both_capt_no_req", m_req, 0);
        @(negedge clk);
        check("both_write_first", m_we, 1);
        check("both_write_addr", m_addr, 64'h4000);
        dv_cyc = 0;
        for (int n = 3; n < 60 && dv_cyc == 0; n++) begin
            @(negedge clk);
            if (c_dv) dv_cyc = n;
        end
        check("both_dv_cycle", dv_cyc, 35);
        c_rd = 1'b0;

        // Reset at beat 7 of a read, then a fresh read.
        c_addr = 64'h0000_0000_0000_5000;
        c_rd   = 1'b1;
        got    = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (m_req && m_addr == 64'h5038) got = 1'b1;
        end
        check("abort_beat7_seen", got, 1);
        clr  = 1'b1;
        c_rd = 1'b0;
        @(negedge clk);
        check("abort_req_low", m_req, 0);
        check("abort_dv_low", c_dv, 0);
        check("abort_busy_low", busy, 0);
        clr    = 1'b0;
        c_addr = 64'h0000_0000_0000_607F;
        c_rd   = 1'b1;
        @(negedge clk);
        check("restart_req", m_req, 1);
        check("restart_addr", m_addr, 64'h6000);
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (c_dv) got = 1'b1;
        end
        check("restart_dv_seen", got, 1);
        c_rd = 1'b0;

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_line_bridge.md
Name: dmem_line_bridge

Overview:
Sits directly downstream of the data cache's line bus. Converts 1024-bit line fills and write-throughs into 16 sequential 64-bit beats on the memory port. Returns a filled line to the cache with a one-cycle valid pulse. Has a single-entry write-pending latch, so a write-through issued in the fill-completion cycle is never lost.

Parameters:
ADDR_W, 64, address width
LINE_W, 1024, cache line width in bits
BEAT_W, 64, memory port data width; BEATS = LINE_W/BEAT_W = 16

Ports:
clk  in  1  clock
clr  in  1  synchronous active-high reset
c_addr  in  ADDR_W  line address from cache; bits [6:0] ignored and forced to 0
c_rd  in  1  line fill request (level)
c_wr  in  1  write-through request (pulse or level; sampled every cycle)
c_wdata  in  LINE_W  line to write; sampled one cycle after c_wr is accepted
c_rdata  out  LINE_W  filled line; held until the next fill completes
c_dv  out  1  one-cycle pulse: c_rdata valid
busy  out  1  bridge not in IDLE, or write pending
m_addr  out  ADDR_W  beat address = line base + 8*beat
m_req  out  1  beat request; held until m_ack
m_we  out  1  1 = write beat
m_wdata  out  BEAT_W  write beat data
m_rdata  in  BEAT_W  read beat data, valid with m_ack
m_ack  in  1  beat completes on an edge where m_req && m_ack

Behaviour:
- Reset (clr=1 at an edge): state IDLE; beat counter 0; write-pending cleared. m_req, m_we, c_dv, busy = 0; m_addr, m_wdata, c_rdata = 0. Reset mid-burst aborts immediately: m_req is low the next cycle. The memory side must tolerate an abandoned beat.
- States: IDLE, RD_BURST, RD_DONE, WR_CAPT, WR_BURST.
- IDLE:
  - If write pending or c_wr: latch line base, go to WR_CAPT.
  - Else if c_rd: latch line base, go to RD_BURST.
  - Write has priority over read.
- WR_CAPT: capture c_wdata into the line buffer; clear pending; go to WR_BURST.
- RD_BURST / WR_BURST:
  - m_req=1; m_we=1 only in WR_BURST.
  - m_addr = base + {beat,3'b000}; m_wdata = buffer[64*beat +: 64].
  - On each acked beat: read stores m_rdata into buffer[64*beat +: 64], beat increments.
  - m_req stays high across beats (back-to-back); m_addr/m_wdata update on the ack edge.
  - After beat 15 acks: beat wraps to 0. RD_BURST goes to RD_DONE; WR_BURST goes to IDLE.
- RD_DONE: c_dv=1 for exactly one cycle, c_rdata = buffer; then IDLE.
- c_rdata is driven from the buffer and is only overwritten by read beats. A write burst never corrupts c_rdata: a separate read buffer is used, or the write buffer is loaded only in WR_CAPT.
- Latency, zero-wait memory (m_ack tied high):
  - c_rd sampled at edge 0; m_req high cycles 1–16; c_dv high in cycle 17.
  - Write: c_wr sampled at edge 0; WR_CAPT in cycle 1; beats in cycles 2–17.
- Write-pending latch:
  - Any c_wr seen outside IDLE sets pending; it is served on the next IDLE.
  - Covers c_wr arriving in the RD_DONE cycle.
  - A second c_wr while pending is already set is merged: one write, data sampled at WR_CAPT.
- c_rd still high in the cycle after RD_DONE (cache not yet updated): one stray cycle is tolerated. The bridge re-samples only in IDLE, and the cache is expected to drop c_rd after c_dv.
- Wait states: m_ack low holds m_req, m_addr, m_we and m_wdata stable.
- busy = (state != IDLE) || pending.

Decomposition:
- Shared package:
  - LINE_W, BEAT_W, BEATS, OFFS_W = 7.
  - State encoding constants ST_IDLE..ST_WR_BURST.
  - Beat counter width $clog2(BEATS).
- No sub-module; FSM, counter and buffers fit in one module of about 200 lines.

Test Plan:
- Read fill, m_ack tied 1, c_addr=0x1234_5678_9ABC_DEF5 → m_addr runs 0x...DE80 to 0x...DEF8 in steps of 8. c_dv pulses in cycle 17 with c_rdata[64*i+:64] = beat i data.
- Read fill, m_ack high every 3rd cycle → m_addr/m_req stable between acks. Exactly 16 acks, then one c_dv; c_rdata correct.
- c_wr pulse with c_wdata = pattern i→0xA5A5_0000_0000_0000+i → 16 beats with m_we=1, m_wdata per beat matching; no c_dv; busy drops after the last ack.
- c_wr asserted in the RD_DONE cycle → c_dv pulses; pending set; WR_CAPT next IDLE cycle; 16 write beats follow to the same base.
- c_rd and c_wr together in IDLE → write burst first, then read burst; c_dv only after the read.
- clr=1 at beat 7 of a read → next cycle m_req=0, c_dv=0, busy=0. A fresh c_rd restarts at beat 0 with the correct base.
